truth_table_scanner: RTL and testbench

Sequential stimulus-and-capture stage wrapped around a 3-input combinational function block. It drives the function's 3-bit `data` input through all eight combinations, samples the function's 1-bit output `f` for each, and assembles the results into an 8-bit truth table. It then compares that table against an expected mask and reports the result with a one-cycle `done` pulse. It sits directly upstream of the function block, feeding its `data`, and directly downstream of it, consuming its `f`.

---
 rtl/truth_table_scanner.sv | 107 ++++++++++
 tb/tb_truth_table_scanner.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_scanner.sv
// Drives a 3-input combinational block through all eight vectors, captures its output as a
// truth table and compares it against a latched expected mask.
module truth_table_scanner #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] expected,
  input  logic       f_in,
  output logic [0:2] data_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       match,
  output logic [3:0] err_count
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StScan = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [3:0] Reload = 4'(SETTLE - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] exp_q, exp_d;
  logic [7:0] result_q, result_d;
  logic [3:0] err_q, err_d;
  logic       match_q, match_d;
  logic       miss;
  logic [3:0] err_inc;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    result_d = result_q;
    err_d    = err_q;
    match_d  = match_q;
    miss     = f_in != exp_q[idx_q];
    err_inc  = err_q + 4'(miss);

    case (state_q)
      StIdle: begin
        if (start) begin
          exp_d    = expected;
          result_d = 8'h00;
          err_d    = 4'd0;
          match_d  = 1'b0;
          idx_d    = 3'd0;
          cnt_d    = Reload;
          state_d  = StScan;
        end
      end
      StScan: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Sample on the last edge of the hold window for this vector.
          result_d[idx_q] = f_in;
          err_d           = err_inc;
          if (idx_q == 3'd7) begin
            match_d = (err_inc == 4'd0);
            state_d = StDone;
          end else begin
            idx_d = idx_q + 3'd1;
            cnt_d = Reload;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= 3'd0;
      cnt_q    <= 4'd0;
      exp_q    <= 8'h00;
      result_q <= 8'h00;
      err_q    <= 4'd0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      result_q <= result_d;
      err_q    <= err_d;
      match_q  <= match_d;
    end
  end

  // data_out[0] is the MSB, so a positional assignment keeps x on bit 0.
  assign data_out  = idx_q;
  assign busy      = (state_q == StScan);
  assign done      = (state_q == StDone);
  assign result    = result_q;
  assign match     = match_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench for truth_table_scanner: one instance at SETTLE=1, one at SETTLE=3 with a
// slow-settling function model that reads wrong until a vector has been held long enough.
module tb_truth_table_scanner;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic       start_a[2];
  logic [7:0] exp_a[2];
  logic [7:0] tbl_a[2];
  logic [0:2] dout_a[2];
  logic       busy_a[2];
  logic       done_a[2];
  logic       match_a[2];
  logic [7:0] res_a[2];
  logic [3:0] err_a[2];
  logic       done_prev[2];

  logic       f1;
  logic       f3;
  logic [0:2] last3 = 3'd0;
  int         stab3 = 0;

  assign f1 = tbl_a[0][dout_a[0]];

  // Count edges a vector has been stable; the slow block only reads right after two of them.
  always @(posedge clk) begin
    last3 <= dout_a[1];
    if (dout_a[1] == last3) stab3 <= (stab3 < 100) ? stab3 + 1 : stab3;
    else stab3 <= 1;
  end
  assign f3 = (stab3 >= 2 && dout_a[1] == last3) ? tbl_a[1][dout_a[1]] : ~tbl_a[1][dout_a[1]];

  truth_table_scanner #(.SETTLE(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_a[0]),
    .expected (exp_a[0]),
    .f_in     (f1),
    .data_out (dout_a[0]),
    .busy     (busy_a[0]),
    .done     (done_a[0]),
    .result   (res_a[0]),
    .match    (match_a[0]),
    .err_count(err_a[0])
  );

  truth_table_scanner #(.SETTLE(3)) u_dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_a[1]),
    .expected (exp_a[1]),
    .f_in     (f3),
    .data_out (dout_a[1]),
    .busy     (busy_a[1]),
    .done     (done_a[1]),
    .result   (res_a[1]),
    .match    (match_a[1]),
    .err_count(err_a[1])
  );

  typedef struct packed {
    logic [7:0] r;
    logic [3:0] e;
    logic       m;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // f = ~((x^y)|z), x the MSB of the vector index.
  function automatic logic [7:0] spec_fn();
    logic [7:0] t;
    logic [2:0] v;
    t = 8'h00;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      t[i] = ~((v[2] ^ v[1]) | v[0]);
    end
    return t;
  endfunction

  function automatic exp_t model(input logic [7:0] tbl, input logic [7:0] ex);
    exp_t e;
    e.r = tbl;
    e.e = 4'($countones(tbl ^ ex));
    e.m = (tbl == ex);
    return e;
  endfunction

  task automatic push(input int k, input exp_t e);
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic mon(input int k);
    exp_t e;
    bit   empty;
    e = '0;
    if (k == 0) begin
      empty = (q0.size() == 0);
      if (!empty) e = q0.pop_front();
    end else begin
      empty = (q1.size() == 0);
      if (!empty) e = q1.pop_front();
    end
    chk($sformatf("done_expected%0d", k), 32'(empty), 32'd0);
    chk($sformatf("done_single%0d", k), 32'(done_prev[k]), 32'd0);
    chk($sformatf("done_busy%0d", k), 32'(busy_a[k]), 32'd0);
    if (!empty) begin
      chk($sformatf("result%0d", k), 32'(res_a[k]), 32'(e.r));
      chk($sformatf("err_count%0d", k), 32'(err_a[k]), 32'(e.e));
      chk($sformatf("match%0d", k), 32'(match_a[k]), 32'(e.m));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done_a[0]) mon(0);
    if (rst_n && done_a[1]) mon(1);
    done_prev[0] <= done_a[0];
    done_prev[1] <= done_a[1];
  end

  task automatic wait_idle(input int k);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (!busy_a[k] && !done_a[k]) begin
        ok = 1'b1;
        break;
      end
    end
    chk($sformatf("idle_reached%0d", k), 32'(ok), 32'd1);
  endtask

  task automatic check_zero(input int k, input string tag);
    chk({tag, "_data_out"}, 32'(dout_a[k]), 32'd0);
    chk({tag, "_busy"}, 32'(busy_a[k]), 32'd0);
    chk({tag, "_done"}, 32'(done_a[k]), 32'd0);
    chk({tag, "_result"}, 32'(res_a[k]), 32'd0);
    chk({tag, "_match"}, 32'(match_a[k]), 32'd0);
    chk({tag, "_err"}, 32'(err_a[k]), 32'd0);
  endtask

  task automatic scan(input int k, input logic [7:0] tbl, input logic [7:0] ex, input bit disturb);
    int   s;
    int   t0;
    bit   seen;
    exp_t e;
    s = (k == 0) ? 1 : 3;
    e = model(tbl, ex);
    wait_idle(k);
    tbl_a[k]   = tbl;
    exp_a[k]   = ex;
    start_a[k] = 1'b1;
    push(k, e);
    @(negedge clk);
    start_a[k] = 1'b0;
    t0 = cyc;
    chk("accept_busy", 32'(busy_a[k]), 32'd1);
    chk("accept_clear_result", 32'(res_a[k]), 32'd0);
    chk("accept_clear_err", 32'(err_a[k]), 32'd0);
    chk("accept_clear_match", 32'(match_a[k]), 32'd0);
    chk("accept_data_out", 32'(dout_a[k]), 32'd0);
    seen = 1'b0;
    for (int n = 0; n < 8 * s + 4; n++) begin
      @(negedge clk);
      if (done_a[k]) begin
        seen = 1'b1;
        break;
      end
      if (disturb) begin
        start_a[k] = 1'($urandom_range(0, 1));
        exp_a[k]   = 8'($urandom);
      end
    end
    start_a[k] = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    if (seen) chk("done_latency", 32'(cyc - t0), 32'(8 * s));
    @(negedge clk);
    chk("done_fell", 32'(done_a[k]), 32'd0);
    chk("hold_result", 32'(res_a[k]), 32'(e.r));
    chk("hold_err", 32'(err_a[k]), 32'(e.e));
    chk("hold_match", 32'(match_a[k]), 32'(e.m));
  endtask

  initial begin
    int times[3];
    int cnt;
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      start_a[k] = 1'b0;
      exp_a[k]   = 8'h00;
      tbl_a[k]   = 8'h00;
    end

    #1 rst_n = 1'b0;
    #2;
    check_zero(0, "reset1");
    check_zero(1, "reset3");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    scan(0, spec_fn(), 8'h41, 1'b0);
    scan(0, spec_fn(), 8'h40, 1'b0);
    scan(0, 8'hFF, 8'h00, 1'b0);
    repeat (6) scan(0, 8'($urandom), 8'($urandom), 1'b1);

    scan(1, spec_fn(), 8'h41, 1'b0);
    repeat (4) scan(1, 8'($urandom), 8'($urandom), 1'b1);

    // Abort a scan partway through with an asynchronous reset.
    wait_idle(0);
    tbl_a[0]   = spec_fn();
    exp_a[0]   = 8'h41;
    start_a[0] = 1'b1;
    push(0, model(spec_fn(), 8'h41));
    @(negedge clk);
    start_a[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_zero(0, "midreset1");
    check_zero(1, "midreset3");
    q0.delete();
    @(negedge clk);
    chk("reset_hold_done", 32'(done_a[0]), 32'd0);
    rst_n = 1'b1;
    scan(0, spec_fn(), 8'h41, 1'b0);

    // Back-to-back scans with start held high.
    wait_idle(0);
    tbl_a[0]   = spec_fn();
    exp_a[0]   = 8'h41;
    start_a[0] = 1'b1;
    e = model(spec_fn(), 8'h41);
    repeat (3) push(0, e);
    cnt = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done_a[0]) begin
        times[cnt] = cyc;
        cnt++;
        if (cnt == 3) begin
          start_a[0] = 1'b0;
          break;
        end
      end
    end
    start_a[0] = 1'b0;
    chk("b2b_count", 32'(cnt), 32'd3);
    if (cnt == 3) begin
      chk("b2b_gap1", 32'(times[1] - times[0]), 32'd10);
      chk("b2b_gap2", 32'(times[2] - times[1]), 32'd10);
    end

    repeat (12) @(negedge clk);
    chk("sb_drained1", 32'(q0.size()), 32'd0);
    chk("sb_drained3", 32'(q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
